// File: rtl/rsc_tail_encoder.sv
// rsc_tail_encoder
//   8-state recursive systematic convolutional encoder (feedback 1+D^2+D^3,
//   feedforward 1+D+D^3) with a one-deep registered output slot.
//
//   Build option: FPTD_TERMINATION_EN
//     defined   - each block is followed by three trellis-termination pairs
//                 that drive the state back to 000 (out_tail=1, out_last on
//                 the third).
//     undefined - no tail; out_last marks the pair of the in_last bit and the
//                 state is cleared to 000 when that bit is accepted.
//
//   Ports
//     Clock, nReset         rising-edge clock, async active-low reset
//     in_valid/in_ready     information-bit handshake (in_bit, in_last)
//     out_valid/out_ready   output-pair handshake (out_sys, out_par,
//                           out_tail, out_last)
//     len_err               block longer than K_MAX bits, sticky until in_last
module rsc_tail_encoder #(
  parameter int K_MAX = 6144,
  parameter int CW    = 13
) (
  input  logic Clock,
  input  logic nReset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_sys,
  output logic out_par,
  output logic out_tail,
  output logic out_last,
  output logic len_err
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIM = CW'(K_MAX);

`ifdef FPTD_TERMINATION_EN
  typedef enum logic {RUN, TAIL} state_e;
  state_e     state_q, state_d;
  logic [1:0] tail_cnt_q, tail_cnt_d;
`endif

  logic          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          len_err_q, len_err_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sys_q, out_sys_d;
  logic          out_par_q, out_par_d;
  logic          out_tail_q, out_tail_d;
  logic          out_last_q, out_last_d;

  logic slot_free, accept, fb;

  always_comb begin
    slot_free = !out_valid_q || out_ready;
`ifdef FPTD_TERMINATION_EN
    in_ready  = (state_q == RUN) && slot_free;
`else
    in_ready  = slot_free;
`endif
    accept = in_valid && in_ready;
    fb     = in_bit ^ d2_q ^ d3_q;

    d1_d        = d1_q;
    d2_d        = d2_q;
    d3_d        = d3_q;
    cnt_d       = cnt_q;
    len_err_d   = len_err_q;
    out_valid_d = out_valid_q;
    out_sys_d   = out_sys_q;
    out_par_d   = out_par_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;
`ifdef FPTD_TERMINATION_EN
    state_d     = state_q;
    tail_cnt_d  = tail_cnt_q;
`endif

    // Slot drains when consumed; a load below refills it in the same cycle.
    if (slot_free) out_valid_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_sys_d   = in_bit;
      out_par_d   = fb ^ d1_q ^ d3_q;
      out_tail_d  = 1'b0;
      d1_d        = fb;
      d2_d        = d1_q;
      d3_d        = d2_q;
      if (in_last) begin
        cnt_d     = '0;
        len_err_d = 1'b0;
`ifdef FPTD_TERMINATION_EN
        out_last_d = 1'b0;
        state_d    = TAIL;
        tail_cnt_d = 2'd0;
`else
        out_last_d = 1'b1;
        d1_d       = 1'b0;
        d2_d       = 1'b0;
        d3_d       = 1'b0;
`endif
      end else begin
        out_last_d = 1'b0;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // cnt_q already counts K_MAX bits, so this is bit K_MAX+1 (or later).
        if (cnt_q >= CNT_LIM) len_err_d = 1'b1;
      end
    end
`ifdef FPTD_TERMINATION_EN
    else if (state_q == TAIL && slot_free) begin
      // Forced input u = d2^d3 cancels the feedback, so zeros shift in.
      out_valid_d = 1'b1;
      out_sys_d   = d2_q ^ d3_q;
      out_par_d   = d1_q ^ d3_q;
      out_tail_d  = 1'b1;
      out_last_d  = (tail_cnt_q == 2'd2);
      d1_d        = 1'b0;
      d2_d        = d1_q;
      d3_d        = d2_q;
      if (tail_cnt_q == 2'd2) begin
        state_d    = RUN;
        tail_cnt_d = 2'd0;
      end else begin
        tail_cnt_d = tail_cnt_q + 2'd1;
      end
    end
`endif
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      d3_q        <= 1'b0;
      cnt_q       <= '0;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef FPTD_TERMINATION_EN
      state_q     <= RUN;
      tail_cnt_q  <= 2'd0;
`endif
    end else begin
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      d3_q        <= d3_d;
      cnt_q       <= cnt_d;
      len_err_q   <= len_err_d;
      out_valid_q <= out_valid_d;
      out_sys_q   <= out_sys_d;
      out_par_q   <= out_par_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
`ifdef FPTD_TERMINATION_EN
      state_q     <= state_d;
      tail_cnt_q  <= tail_cnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sys   = out_sys_q;
  assign out_par   = out_par_q;
  assign out_last  = out_last_q;
  assign len_err   = len_err_q;
`ifdef FPTD_TERMINATION_EN
  assign out_tail  = out_tail_q;
`else
  assign out_tail  = 1'b0;
`endif

endmodule

// File: tb/tb_rsc_tail_encoder.sv
// Directed bench for rsc_tail_encoder; expectations adapt to FPTD_TERMINATION_EN.
// Pairs are recorded as {sys, par, tail, last}.
module tb_rsc_tail_encoder;

`ifdef FPTD_TERMINATION_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif

  logic Clock = 1'b0, nReset = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_sys, out_par, out_tail, out_last, len_err;

  int n_chk = 0, n_fail = 0;
  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  rsc_tail_encoder #(.K_MAX(20), .CW(5)) dut (
    .Clock(Clock), .nReset(nReset),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sys(out_sys), .out_par(out_par), .out_tail(out_tail), .out_last(out_last),
    .len_err(len_err)
  );

  always #5 Clock = ~Clock;

  // Record every consumed pair.
  always @(negedge Clock)
    if (nReset && out_valid && out_ready)
      got_q.push_back({out_sys, out_par, out_tail, out_last});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clock);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge Clock);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_pair%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lowcnt;

    // Reset state
    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_sys, out_par, out_tail, out_last}, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_in_ready", in_ready, 1);
    nReset = 1'b1;
    idle(2);

    // Block 1,0,1,1
    send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(1, 1);
    idle(6);
    exp_q.push_back(4'b1100); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
    exp_q.push_back({3'b110, !TERM});
`ifdef FPTD_TERMINATION_EN
    exp_q.push_back(4'b0010); exp_q.push_back(4'b0010); exp_q.push_back(4'b0011);
`endif
    cmp_q("blk1011");

    // Block 1,1: tail pairs and in_ready gap
    send_bit(1, 0); send_bit(1, 1);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (in_ready) break;
      lowcnt++;
    end
    chk("tail_ready_low", lowcnt, TERM ? 3 : 0);
    idle(6);
    exp_q.push_back(4'b1100); exp_q.push_back({3'b100, !TERM});
`ifdef FPTD_TERMINATION_EN
    exp_q.push_back(4'b1110); exp_q.push_back(4'b0110); exp_q.push_back(4'b1111);
`endif
    cmp_q("blk11");

    // Back-pressure: 4 stalled cycles with a bit pending
    send_bit(1, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      chk($sformatf("stall_ready%0d", i), in_ready, 0);
      chk($sformatf("stall_hold%0d", i), {out_valid, out_sys, out_par, out_tail, out_last}, 5'b11100);
    end
    @(posedge Clock); #1;
    out_ready = 1'b1;
    send_bit(0, 0); send_bit(1, 1);
    idle(6);
    exp_q.push_back(4'b1100); exp_q.push_back(4'b0100); exp_q.push_back({3'b100, !TERM});
`ifdef FPTD_TERMINATION_EN
    exp_q.push_back(4'b1110); exp_q.push_back(4'b0010); exp_q.push_back(4'b0011);
`endif
    cmp_q("stall");

    // Over-length block with counter saturation (K_MAX=20, 2^CW-1=31)
    for (int i = 0; i < 20; i++) send_bit(0, 0);
    chk("len_err_at_kmax", len_err, 0);
    send_bit(0, 0);
    chk("len_err_kmax_p1", len_err, 1);
    for (int i = 0; i < 19; i++) send_bit(0, 0);
    chk("len_err_sticky", len_err, 1);
    send_bit(1, 1);
    chk("len_err_clear", len_err, 0);
    idle(6);
    for (int i = 0; i < 40; i++) exp_q.push_back(4'b0000);
    exp_q.push_back({3'b110, !TERM});
`ifdef FPTD_TERMINATION_EN
    exp_q.push_back(4'b0110); exp_q.push_back(4'b1010); exp_q.push_back(4'b1111);
`endif
    cmp_q("longblk");

    // Counter cleared by the over-length block's in_last
    for (int i = 0; i < 20; i++) send_bit(0, 0);
    chk("len_err_new_blk", len_err, 0);
    send_bit(0, 1);
    idle(6);
    got_q.delete();

    // Reset mid-tail (or mid-block without termination)
    send_bit(1, 0); send_bit(1, TERM);
`ifdef FPTD_TERMINATION_EN
    repeat (2) @(posedge Clock);
    #1;
    chk("pre_rst_tail", {out_valid, out_tail}, 2'b11);
`endif
    nReset = 1'b0;
    #1;
    chk("mid_rst_outs", {out_valid, out_sys, out_par, out_tail, out_last, len_err}, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge Clock); #1;
    nReset = 1'b1;
    got_q.delete();
    send_bit(1, 1);
    idle(6);
    exp_q.push_back({3'b110, !TERM});
`ifdef FPTD_TERMINATION_EN
    exp_q.push_back(4'b0110); exp_q.push_back(4'b1010); exp_q.push_back(4'b1111);
`endif
    cmp_q("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rsc_tail_encoder.md
RSC_TAIL_ENCODER -- requirements
Module: rsc_tail_encoder

Interface
REQ-001 SHALL have parameter K_MAX, default 6144: maximum information bits per block.
REQ-002 SHALL have parameter CW, default 13: block bit-counter width; requires 2^CW > K_MAX.
REQ-003 SHALL have port Clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nReset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: information bit offered.
REQ-006 SHALL have port in_ready, output, 1: encoder accepts the offered bit this cycle.
REQ-007 SHALL have port in_bit, input, 1: information bit u.
REQ-008 SHALL have port in_last, input, 1: the offered bit is the last bit of its block.
REQ-009 SHALL have port out_valid, output, 1: an output pair is held.
REQ-010 SHALL have port out_ready, input, 1: the downstream stage consumes the held pair.
REQ-011 SHALL have port out_sys, output, 1: systematic bit, or tail systematic bit.
REQ-012 SHALL have port out_par, output, 1: parity bit.
REQ-013 SHALL have port out_tail, output, 1: the held pair is a termination pair.
REQ-014 SHALL have port out_last, output, 1: the held pair is the final pair of the block.
REQ-015 SHALL have port len_err, output, 1: the block exceeded K_MAX bits (sticky within a block).

Function
REQ-016 The encoder SHALL be an 8-state RSC with feedback 1+D^2+D^3 and feedforward 1+D+D^3, using shift registers d1 (newest), d2 and d3.
- Feedback: a = u^d2^d3.
- Outputs: out_sys = u, out_par = a^d1^d3.
- Next state: d1<=a, d2<=d1, d3<=d2.
REQ-017 A transfer SHALL occur on each cycle with in_valid && in_ready; out_* SHALL be registered, giving 1-cycle latency from accepted input to out_valid.
REQ-018 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready), so the encoder accepts and drains in the same cycle at full throughput.
REQ-019 out_valid SHALL hold, and out_* SHALL remain stable, until out_ready is high; in_bit and in_last SHALL be ignored when no transfer occurs.
REQ-020 The FSM SHALL have two states:
- RUN: encode data; an accepted bit with in_last high moves to TAIL with tail_cnt=0.
- TAIL: in_ready low; one tail pair is loaded whenever the output slot is free; after tail_cnt reaches 2 and that pair is loaded, the FSM returns to RUN.
REQ-021 Each tail pair SHALL be computed with forced input u = d2^d3, so a = 0:
- out_sys = d2^d3, out_par = d1^d3, out_tail = 1.
- The state shifts with d1<=0.
- After three tail pairs, the state is 000.
REQ-022 out_last SHALL be 1 on the third tail pair and 0 on every other pair.
REQ-023 The block counter SHALL increment on each accepted data bit, saturate at 2^CW-1, and clear when the last data bit of a block is accepted.
REQ-024 len_err SHALL be set in the cycle after the (K_MAX+1)-th data bit of a block is accepted, and cleared when in_last is accepted.
REQ-025 If in_last arrives with the counter already saturated, the encoder SHALL still terminate normally.

Reset
REQ-026 While nReset is low, the encoder SHALL immediately force:
- FSM=RUN, d1=d2=d3=0, tail_cnt=0, block counter=0.
- out_valid=0, out_sys=0, out_par=0, out_tail=0, out_last=0, len_err=0.
REQ-027 A reset asserted mid-block or mid-tail SHALL abandon that block with no partial tail; the next accepted bit SHALL start a new block from state 000.

Configuration
REQ-028 Macro FPTD_TERMINATION_EN SHALL select the termination behaviour:
- Defined: REQ-020 to REQ-022 apply.
- Undefined: there is no TAIL state and in_ready = !out_valid || out_ready always; out_tail is tied 0; out_last is 1 on the pair of the accepted in_last bit; the state is cleared to 000 on that acceptance.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then bits 1,0,1,1 with in_last on the fourth -> data pairs (1,1),(0,1),(1,0),(1,1), then tail pairs (0,0),(0,0),(0,0) with the last flagged by out_last.
- Bits 1,1 with in_last on the second -> data pairs (1,1),(1,0), then tail pairs (1,1),(0,1),(1,1) with out_tail=1; in_ready low for 3 cycles.
- out_ready held low for 4 cycles mid-block -> out_* stable, in_ready=0, no bit lost or duplicated.
- K_MAX+1 bits without in_last -> len_err rises after bit K_MAX+1; in_last clears it and three tail pairs follow.
- nReset pulsed during the second tail pair -> all outputs 0 immediately; the next block's first pair encodes from 000 (bit 1 gives (1,1)).
- With FPTD_TERMINATION_EN undefined, bits 1,1 with in_last -> (1,1),(1,0) with out_last on the second pair; the next bit 1 gives (1,1).
